// File: rtl/if_fetch_if.sv
// Byte-wide read port between the fetch stage (master) and the memory controller (slave).
interface if_fetch_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_valid_i;
  logic [7:0]        mem_data_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_valid_i,
    input  mem_data_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_valid_i,
    output mem_data_i
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: assembles each 32-bit word from four byte reads and presents
// {if_pc, if_inst} to IF/ID, stalling the front end until the word is complete.
module if_fetch #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  if_fetch_if.master        mem,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_inst
);

  typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       inst_buf_q, inst_buf_d;

  // Only stall[0] concerns this stage; the other bits belong to later stages.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    byte_cnt_d = byte_cnt_q;
    inst_buf_d = inst_buf_q;
    if (state_q == StIdle) begin
      state_d    = StFetch;
      byte_cnt_d = 2'd0;
    end else if (branch_flag_i) begin
      // Redirect wins over stall and any byte returned this cycle.
      state_d    = StFetch;
      pc_d       = branch_target_i;
      byte_cnt_d = 2'd0;
      inst_buf_d = '0;
    end else if (state_q == StFetch) begin
      if (mem.mem_valid_i) begin
        inst_buf_d[8*byte_cnt_q +: 8] = mem.mem_data_i;
        byte_cnt_d                    = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          state_d = StDone;
        end
      end
    end else if (!stall[0]) begin
      pc_d    = pc_q + ADDR_W'(4);
      state_d = StFetch;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      byte_cnt_q <= 2'd0;
      inst_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      byte_cnt_q <= byte_cnt_d;
      inst_buf_q <= inst_buf_d;
    end
  end

  assign mem.mem_req_o  = (state_q == StFetch);
  assign mem.mem_addr_o = pc_q + ADDR_W'(byte_cnt_q);
  // Gated by rst so the request is low while reset is held, high in IDLE afterwards.
  assign stallreq_o     = rst && (state_q != StDone);
  assign if_pc          = pc_q;
  assign if_inst        = (state_q == StDone) ? inst_buf_q : 32'd0;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: byte-memory responder, transaction-level model and
// per-cycle compare, plus hand-computed expectations at key points.
module tb_if_fetch;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [5:0]    stall = '0;
  logic          branch_flag = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic          stallreq;
  logic [AW-1:0] if_pc;
  logic [31:0]   if_inst;

  if_fetch_if #(.ADDR_W(AW)) mem_bus ();

  if_fetch #(.ADDR_W(AW), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target),
    .mem             (mem_bus),
    .stallreq_o      (stallreq),
    .if_pc           (if_pc),
    .if_inst         (if_inst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte memory and responder; valid on every period-th requested cycle.
  logic [7:0] mem [512];
  int period = 1;
  int gcnt = 0;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'((i * 37 + 11) & 255);
    mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h00;
    mem[256] = 8'h93; mem[257] = 8'h00; mem[258] = 8'h10; mem[259] = 8'h00;
  end

  always @(negedge clk) begin
    if (mem_bus.mem_req_o) begin
      gcnt++;
      mem_bus.mem_valid_i = ((gcnt % period) == 0);
      mem_bus.mem_data_i  = mem[mem_bus.mem_addr_o[8:0]];
    end else begin
      // Junk bytes outside FETCH must be ignored.
      mem_bus.mem_valid_i = 1'b1;
      mem_bus.mem_data_i  = 8'hFF;
    end
  end

  // Model: 0 idle, 1 fetching, 2 presenting.
  int            m_phase;
  logic [AW-1:0] m_pc;
  logic [7:0]    mq[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_pc = 32'h0; mq.delete();
    end else if (m_phase == 0) begin
      m_phase = 1; mq.delete();
    end else if (branch_flag) begin
      m_phase = 1; m_pc = branch_target; mq.delete();
    end else if (m_phase == 1) begin
      if (mem_bus.mem_valid_i) begin
        mq.push_back(mem_bus.mem_data_i);
        if (mq.size() == 4) m_phase = 2;
      end
    end else if (!stall[0]) begin
      m_phase = 1; m_pc = m_pc + 32'd4; mq.delete();
    end
  end

  always @(negedge clk) begin
    #4;
    if (!rst) begin
      check("rst_req", 64'(mem_bus.mem_req_o), 64'd0);
      check("rst_stallreq", 64'(stallreq), 64'd0);
      check("rst_addr", 64'(mem_bus.mem_addr_o), 64'h0);
    end else begin
      check("cyc_req", 64'(mem_bus.mem_req_o), 64'(m_phase == 1));
      check("cyc_stallreq", 64'(stallreq), 64'(m_phase != 2));
      check("cyc_pc", 64'(if_pc), 64'(m_pc));
      check("cyc_inst", 64'(if_inst),
            (m_phase == 2) ? 64'({mq[3], mq[2], mq[1], mq[0]}) : 64'd0);
      if (m_phase == 1)
        check("cyc_addr", 64'(mem_bus.mem_addr_o), 64'(m_pc + 32'(mq.size())));
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    do begin
      tick();
      n++;
    end while (stallreq && n < bound);
    if (stallreq) begin
      failures++;
      $display("FAIL wait_done: timeout after %0d cycles", bound);
    end
  endtask

  task automatic wait_addr(input logic [AW-1:0] a, input int bound);
    int n = 0;
    while (mem_bus.mem_addr_o !== a && n < bound) begin
      tick();
      n++;
    end
    if (mem_bus.mem_addr_o !== a) begin
      failures++;
      $display("FAIL wait_addr: got %h expected %h", mem_bus.mem_addr_o, a);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 64'(mem_bus.mem_req_o), 64'd0);
    check({tag, "_addr"}, 64'(mem_bus.mem_addr_o), 64'h0);
    check({tag, "_stallreq"}, 64'(stallreq), 64'd0);
    check({tag, "_pc"}, 64'(if_pc), 64'h0);
    check({tag, "_inst"}, 64'(if_inst), 64'd0);
  endtask

  initial begin
    int n;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    #1;
    check("idle_stallreq", 64'(stallreq), 64'd1);
    check("idle_req", 64'(mem_bus.mem_req_o), 64'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!stallreq) break;
      n++;
    end
    check("fetch_cycles", 64'(n), 64'd4);
    check("done0_pc", 64'(if_pc), 64'h0);
    check("done0_inst", 64'(if_inst), 64'h0050_0013);
    check("done0_req", 64'(mem_bus.mem_req_o), 64'd0);
    tick();
    check("next_addr", 64'(mem_bus.mem_addr_o), 64'h4);
    check("next_req", 64'(mem_bus.mem_req_o), 64'd1);

    // Gapped memory, then hold in DONE.
    period = 3;
    stall = 6'b000001;
    wait_done(60);
    check("gap_inst", 64'(if_inst), 64'h0EE9_C49F);
    check("gap_pc", 64'(if_pc), 64'h4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_inst", 64'(if_inst), 64'h0EE9_C49F);
      check("hold_pc", 64'(if_pc), 64'h4);
      check("hold_req", 64'(mem_bus.mem_req_o), 64'd0);
    end
    stall = 6'b0;
    tick();
    check("release_addr", 64'(mem_bus.mem_addr_o), 64'h8);

    // Redirect after two bytes, with a byte valid on the same cycle.
    period = 1;
    wait_addr(32'hA, 10);
    check("br_valid_same_cycle", 64'(mem_bus.mem_valid_i), 64'd1);
    branch_flag = 1'b1;
    branch_target = 32'h100;
    stall = 6'b000001;
    tick();
    branch_flag = 1'b0;
    check("br_addr", 64'(mem_bus.mem_addr_o), 64'h100);
    wait_done(20);
    check("br_inst", 64'(if_inst), 64'h0010_0093);
    check("br_pc", 64'(if_pc), 64'h100);

    // Redirect while held in DONE, to the top of the address space.
    tick(); tick();
    branch_flag = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    branch_flag = 1'b0;
    check("brdone_req", 64'(mem_bus.mem_req_o), 64'd1);
    check("brdone_addr", 64'(mem_bus.mem_addr_o), 64'hFFFF_FFFC);
    check("brdone_inst", 64'(if_inst), 64'd0);
    wait_done(20);
    check("top_inst", 64'(if_inst), 64'hE6C1_9C77);
    check("top_pc", 64'(if_pc), 64'hFFFF_FFFC);
    stall = 6'b0;
    tick();
    check("wrap_pc", 64'(if_pc), 64'h0);
    check("wrap_addr", 64'(mem_bus.mem_addr_o), 64'h0);

    // Asynchronous reset mid-fetch.
    wait_addr(32'h2, 10);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick(); tick();
    rst = 1'b1;
    wait_done(20);
    check("post_rst_pc", 64'(if_pc), 64'h0);
    check("post_rst_inst", 64'(if_inst), 64'h0050_0013);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
